ex_block: RTL

- Execute stage of the 8-bit MIPS pipeline; the request-issuing end of the data-memory interface.
- Computes the ALU result or memory address and registers it as ans_ex.
- Registers store data (DM_data) and the memory controls mem_en_ex, mem_rw_ex and mem_mux_sel_ex that the DM stage consumes on the next cycle.
- Also performs operand forwarding from the EX and DM stages, keeps a carry flag, and flags load-use hazards.

---
 rtl/ex_block_pkg.sv | 45 ++++
 rtl/ex_alu.sv | 60 ++++++
 rtl/ex_block.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ex_block_pkg.sv
// ----------------------------------------------------------------------------
// ex_block_pkg
// Shared definitions for the execute stage of the 8-bit MIPS pipeline:
// datapath / register-address widths, ALU operation encodings, the memory
// read/write encoding, and a helper that says which ALU ops own the carry flag.
// ----------------------------------------------------------------------------
package ex_block_pkg;

    localparam int DW = 8;
    localparam int AW = 3;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOTA = 4'd5,
        ALU_SHL  = 4'd6,
        ALU_SHR  = 4'd7,
        ALU_ASR  = 4'd8,
        ALU_ADC  = 4'd9,
        ALU_SBB  = 4'd10,
        ALU_PASB = 4'd11,
        ALU_INC  = 4'd12,
        ALU_DEC  = 4'd13,
        ALU_SLT  = 4'd14,
        ALU_SLTU = 4'd15
    } alu_op_e;

    localparam logic MEM_WR = 1'b1;
    localparam logic MEM_RD = 1'b0;

    // True for the ops whose carry-out / borrow is written to the carry flag.
    function automatic logic is_carry_op(input logic [3:0] op);
        logic hit;
        case (op)
            ALU_ADD, ALU_ADC, ALU_INC,
            ALU_SUB, ALU_SBB, ALU_DEC: hit = 1'b1;
            default:                   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ex_alu.sv
// ----------------------------------------------------------------------------
// ex_alu
// Purely combinational ALU of the execute stage.
//   a, b       : operands (b is already the immediate or forwarded rt)
//   op         : ALU operation (ex_block_pkg::alu_op_e encoding)
//   cin        : current carry flag, consumed by ADC / SBB
//   result     : operation result mod 2^DW
//   cout       : carry-out (add family) or borrow (subtract family)
//   cout_valid : 1 when op is allowed to update the carry flag
// ----------------------------------------------------------------------------
module ex_alu #(
    parameter int DW = ex_block_pkg::DW
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [3:0]    op,
    input  logic          cin,
    output logic [DW-1:0] result,
    output logic          cout,
    output logic          cout_valid
);
    import ex_block_pkg::*;

    // One extra bit: the top bit is carry for adds and borrow for subtracts.
    logic [DW:0] wide_s;
    logic [DW:0] cin_ext_s;
    logic [DW:0] one_ext_s;

    assign cin_ext_s = {{DW{1'b0}}, cin};
    assign one_ext_s = {{DW{1'b0}}, 1'b1};

    // Operation select; shift amount is always b[2:0].
    always_comb begin
        wide_s = {(DW+1){1'b0}};
        result = {DW{1'b0}};
        cout   = 1'b0;
        case (op)
            ALU_ADD:  begin wide_s = {1'b0, a} + {1'b0, b};             result = wide_s[DW-1:0]; cout = wide_s[DW]; end
            ALU_SUB:  begin wide_s = {1'b0, a} - {1'b0, b};             result = wide_s[DW-1:0]; cout = wide_s[DW]; end
            ALU_ADC:  begin wide_s = {1'b0, a} + {1'b0, b} + cin_ext_s; result = wide_s[DW-1:0]; cout = wide_s[DW]; end
            ALU_SBB:  begin wide_s = {1'b0, a} - {1'b0, b} - cin_ext_s; result = wide_s[DW-1:0]; cout = wide_s[DW]; end
            ALU_INC:  begin wide_s = {1'b0, a} + one_ext_s;             result = wide_s[DW-1:0]; cout = wide_s[DW]; end
            ALU_DEC:  begin wide_s = {1'b0, a} - one_ext_s;             result = wide_s[DW-1:0]; cout = wide_s[DW]; end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOTA: result = ~a;
            ALU_SHL:  result = a << b[2:0];
            ALU_SHR:  result = a >> b[2:0];
            ALU_ASR:  result = $signed(a) >>> b[2:0];
            ALU_PASB: result = b;
            ALU_SLT:  result = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(DW-1){1'b0}}, (a < b)};
            default:  result = {DW{1'b0}};
        endcase
    end

    assign cout_valid = is_carry_op(op);

endmodule

// File: rtl/ex_block.sv
// ----------------------------------------------------------------------------
// ex_block
// Execute stage of the 8-bit MIPS pipeline and the request-issuing end of the
// data-memory interface. Forwards rs/rt from EX and DM, runs the ALU, and
// registers the result/address, store data and memory controls for DM.
//   Inputs : clk, reset (sync, active-low), ID operands/immediate/controls,
//            DM-stage result for forwarding, stall, flush
//   Outputs: ans_ex, DM_data, rd_ex, carry and controls (registered);
//            zero, load_hazard (combinational)
// Edge priority: reset > flush > stall > normal update.
// ----------------------------------------------------------------------------
module ex_block #(
    parameter int DW = ex_block_pkg::DW,
    parameter int AW = ex_block_pkg::AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] A_id,
    input  logic [DW-1:0] B_id,
    input  logic [DW-1:0] imm_id,
    input  logic          sel_imm_id,
    input  logic [3:0]    alu_op_id,
    input  logic [AW-1:0] rs_id,
    input  logic [AW-1:0] rt_id,
    input  logic [AW-1:0] rd_id,
    input  logic          wr_en_id,
    input  logic          mem_en_id,
    input  logic          mem_rw_id,
    input  logic          mem_mux_sel_id,
    input  logic [DW-1:0] ans_dm,
    input  logic [AW-1:0] rd_dm,
    input  logic          wr_en_dm,
    input  logic          stall,
    input  logic          flush,
    output logic [DW-1:0] ans_ex,
    output logic [DW-1:0] DM_data,
    output logic          mem_en_ex,
    output logic          mem_rw_ex,
    output logic          mem_mux_sel_ex,
    output logic          wr_en_ex,
    output logic [AW-1:0] rd_ex,
    output logic          carry,
    output logic          zero,
    output logic          load_hazard
);
    import ex_block_pkg::*;

    logic [DW-1:0] ans_r, dm_data_r;
    logic [AW-1:0] rd_r;
    logic          mem_en_r, mem_rw_r, mem_mux_r, wr_en_r, carry_r;

    logic [DW-1:0] fwd_a_s, fwd_b_s, op_b_s, alu_res_s;
    logic          alu_cout_s, alu_cv_s;

    // rs forwarding: EX result beats DM result; R0 is never forwarded.
    always_comb begin
        fwd_a_s = A_id;
        if (wr_en_r && (rd_r == rs_id) && (rs_id != {AW{1'b0}})) begin
            fwd_a_s = ans_r;
        end else if (wr_en_dm && (rd_dm == rs_id) && (rs_id != {AW{1'b0}})) begin
            fwd_a_s = ans_dm;
        end else begin
            fwd_a_s = A_id;
        end
    end

    // rt forwarding, same rules; this value is also the store data.
    always_comb begin
        fwd_b_s = B_id;
        if (wr_en_r && (rd_r == rt_id) && (rt_id != {AW{1'b0}})) begin
            fwd_b_s = ans_r;
        end else if (wr_en_dm && (rd_dm == rt_id) && (rt_id != {AW{1'b0}})) begin
            fwd_b_s = ans_dm;
        end else begin
            fwd_b_s = B_id;
        end
    end

    // ALU operand B: immediate or forwarded rt.
    always_comb begin
        op_b_s = fwd_b_s;
        if (sel_imm_id) begin
            op_b_s = imm_id;
        end else begin
            op_b_s = fwd_b_s;
        end
    end

    ex_alu #(.DW(DW)) u_alu (
        .a          (fwd_a_s),
        .b          (op_b_s),
        .op         (alu_op_id),
        .cin        (carry_r),
        .result     (alu_res_s),
        .cout       (alu_cout_s),
        .cout_valid (alu_cv_s)
    );

    // EX pipeline registers. Flush only kills the controls, so the data
    // registers keep their last values while the bubble passes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ans_r     <= {DW{1'b0}};
            dm_data_r <= {DW{1'b0}};
            rd_r      <= {AW{1'b0}};
            mem_en_r  <= 1'b0;
            mem_rw_r  <= 1'b0;
            mem_mux_r <= 1'b0;
            wr_en_r   <= 1'b0;
            carry_r   <= 1'b0;
        end else if (flush) begin
            mem_en_r  <= 1'b0;
            mem_rw_r  <= 1'b0;
            mem_mux_r <= 1'b0;
            wr_en_r   <= 1'b0;
        end else if (stall) begin
            ans_r     <= ans_r;
            dm_data_r <= dm_data_r;
            rd_r      <= rd_r;
            mem_en_r  <= mem_en_r;
            mem_rw_r  <= mem_rw_r;
            mem_mux_r <= mem_mux_r;
            wr_en_r   <= wr_en_r;
            carry_r   <= carry_r;
        end else begin
            ans_r     <= alu_res_s;
            dm_data_r <= fwd_b_s;
            rd_r      <= rd_id;
            mem_en_r  <= mem_en_id;
            mem_rw_r  <= mem_rw_id;
            mem_mux_r <= mem_mux_sel_id;
            wr_en_r   <= wr_en_id;
            carry_r   <= alu_cv_s ? alu_cout_s : carry_r;
        end
    end

    assign ans_ex         = ans_r;
    assign DM_data        = dm_data_r;
    assign rd_ex          = rd_r;
    assign mem_en_ex      = mem_en_r;
    assign mem_rw_ex      = mem_rw_r;
    assign mem_mux_sel_ex = mem_mux_r;
    assign wr_en_ex       = wr_en_r;
    assign carry          = carry_r;
    assign zero           = (ans_r == {DW{1'b0}});

    // A load in EX only has its address in ans_ex, so a dependent ID
    // instruction cannot be satisfied by forwarding and must stall.
    assign load_hazard = mem_en_r && (mem_rw_r == MEM_RD) && mem_mux_r && wr_en_r &&
                         (rd_r != {AW{1'b0}}) && ((rd_r == rs_id) || (rd_r == rt_id));

endmodule
